spi_master: RTL
===============

// Module: spi_master
// PURPOSE
//  SPI mode-0 master: the initiator end of the FPGA's SPI slave port, for driving external
//  SPI peripherals (codec control, flash) from fabric logic.
//  Byte-oriented: the user logic hands one byte at a time; bits go out MSB first on
//  spi_mosi_o, and the byte read back on spi_miso_i is returned.
//  Chip-select can be held low across consecutive bytes for multi-byte frames.
// PARAMETERS
//  CLK_DIV   4  clk_i cycles per SCK half-period (>=1); SCK = clk_i/(2*CLK_DIV)
//  CS_SETUP  2  clk_i cycles from CS falling to first SCK rising edge (>=1)
//  CS_HOLD   2  clk_i cycles from last SCK falling edge to CS rising (>=1)
// PORTS
//  clk_i       in   1  system clock; every register except async reset is on posedge
//  rst_i       in   1  reset, asynchronous, active-high
//  start_i     in   1  request one byte transfer; accepted only when busy_o=0
//  tx_data_i   in   8  byte to send; sampled on the acceptance cycle
//  last_i      in   1  1 = release CS after this byte; sampled with tx_data_i
//  rx_data_o   out  8  byte received; valid from the done_o cycle until the next done_o
//  busy_o      out  1  1 while a byte is in flight or CS setup/hold is running
//  done_o      out  1  one-cycle pulse when rx_data_o is updated
//  spi_sck_o   out  1  SPI clock; idles low (CPOL=0)
//  spi_mosi_o  out  1  master out; changes on SCK falling edge or before the first rising edge
//  spi_miso_i  in   1  master in; sampled on the clk_i edge that raises SCK
//  spi_cs_o    out  1  chip select, active-low; idles high
// BEHAVIOUR
//  Reset (async, any state): spi_cs_o=1, spi_sck_o=0, spi_mosi_o=0, busy_o=0, done_o=0,
//   rx_data_o=8'h00, state=IDLE, all counters 0. Takes effect mid-byte with no completion.
//  States: IDLE, SETUP, XFER, WAIT (CS held low, idle), HOLD.
//  IDLE:  start_i=1 -> latch tx/last, cs_o<=0, mosi<=tx[7], busy<=1, go SETUP.
//  SETUP: count CS_SETUP cycles, then XFER.
//  XFER:  16 half-periods of CLK_DIV cycles each; SCK toggles at every half-period end.
//         Rising edge: shift miso into rx shift register.
//         Falling edge: present the next tx bit on mosi.
//         After the 8th falling edge (SCK=0): rx_data_o<=shift, done_o=1 for one cycle.
//         Then go to HOLD if last=1, else to WAIT; busy_o=0 in WAIT.
//  WAIT:  CS stays low, SCK low. start_i=1 -> latch, mosi<=tx[7], go XFER directly
//         (no SETUP). last_i is never allowed to leave CS low forever; the user must end
//         the frame with a byte that has last_i=1.
//  HOLD:  count CS_HOLD cycles, then cs_o<=1, go IDLE, busy_o=0. CS stays high >=1 cycle
//         before the next SETUP.
//  Latency: done_o is asserted 1+CS_SETUP+16*CLK_DIV cycles after the acceptance edge from
//   IDLE, and 1+16*CLK_DIV cycles from WAIT.
//  start_i while busy_o=1 is ignored (no queueing); start_i on the done_o cycle is ignored.
//  busy_o falls in the cycle after done_o when entering WAIT, and after HOLD otherwise.
//  CLK_DIV=1: SCK toggles every clk_i cycle; sampling rules are unchanged.
//  Counters: half-period counter is $clog2(CLK_DIV+1) bits and wraps to 0 at CLK_DIV-1;
//   the edge counter is 5 bits (0..16).
// STRUCTURE
//  Package spi_pkg: state encoding localparams (IDLE/SETUP/XFER/WAIT/HOLD), SPI mode
//   constants (CPOL=0, CPHA=0), byte width 8. This package is shared with the slave block.
//  Sub-module spi_sck_gen: half-period counter with enable; emits rise_stb/fall_stb
//   strobes and drives spi_sck_o. The FSM, shifters and handshake live in spi_master.
// TESTING (CLK_DIV=2, CS_SETUP=1, CS_HOLD=1 unless stated)
//  1. Loopback (MISO tied to MOSI), start tx=8'hA5 last=1 from IDLE -> rx_data_o=8'hA5;
//     done_o at cycle 34 after acceptance; 8 SCK rising edges; CS low->high with hold=1.
//  2. Slave model returns 8'h3C while master sends 8'hC3 -> MOSI bit sequence
//     1,1,0,0,0,0,1,1 is stable at each rising edge; rx_data_o=8'h3C.
//  3. Frame 8'h01 (last=0) then 8'h02 (last=1), issued on the first cycle busy_o=0
//     -> CS stays low throughout; 16 rising edges; done_o pulses twice; second done_o
//     comes 33 cycles after its acceptance.
//  4. start_i held high during the whole byte -> exactly one transfer; no retrigger
//     before busy_o=0.
//  5. rst_i pulse after the 3rd SCK rising edge -> same-cycle CS=1, SCK=0, no done_o;
//     the next transfer of 8'h5A completes correctly.
//  6. CLK_DIV=1, tx=8'hFF, MISO=0 -> SCK period is 2 clk_i cycles; rx_data_o=8'h00;
//     done_o at cycle 18.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, mode-0 constants and byte width.
// The master and slave blocks both import this package.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        WAIT  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam logic       CPOL   = 1'b0;
    localparam logic       CPHA   = 1'b0;
    localparam int         BYTE_W = 8;
    // One byte spans 8 rising plus 8 falling SCK edges.
    localparam logic [4:0] EDGES  = 5'd16;

endpackage

// File: rtl/spi_master_if.sv
// User-side byte handshake plus SPI pins of the SPI master.
// The master modport is the controller's view; the slave modport is the user/peripheral side.
interface spi_master_if import spi_pkg::*; ();

    logic              start_i;
    logic [BYTE_W-1:0] tx_data_i;
    logic              last_i;
    logic [BYTE_W-1:0] rx_data_o;
    logic              busy_o;
    logic              done_o;
    logic              spi_sck_o;
    logic              spi_mosi_o;
    logic              spi_miso_i;
    logic              spi_cs_o;

    modport master (
        input  start_i, tx_data_i, last_i, spi_miso_i,
        output rx_data_o, busy_o, done_o, spi_sck_o, spi_mosi_o, spi_cs_o
    );

    modport slave (
        output start_i, tx_data_i, last_i, spi_miso_i,
        input  rx_data_o, busy_o, done_o, spi_sck_o, spi_mosi_o, spi_cs_o
    );

endinterface

// File: rtl/spi_sck_gen.sv
// SCK generator: counts CLK_DIV cycles per half-period while enabled and toggles SCK.
// The strobes are high in the cycle before the edge, so the edge and the strobe share a clk_i edge.
module spi_sck_gen import spi_pkg::*; #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en,
    output logic rise_stb,
    output logic fall_stb,
    output logic sck_o
);

    localparam int            CW       = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          sck_q;
    logic          half_end;

    assign half_end = en && (cnt == CNT_LAST);
    assign rise_stb = half_end && !sck_q;
    assign fall_stb = half_end && sck_q;
    assign sck_o    = sck_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt   <= '0;
            sck_q <= CPOL;
        end else if (!en) begin
            cnt   <= '0;
        end else begin
            cnt <= half_end ? '0 : cnt + CW'(1);
            if (half_end)
                sck_q <= ~sck_q;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: byte-at-a-time transfers, MSB first, CS optionally held across bytes.
// FSM, shift registers and user handshake; SCK timing comes from spi_sck_gen.
module spi_master import spi_pkg::*; #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    spi_master_if.master bus
);

    localparam int              PH_MAX     = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int              PH_W       = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(CS_SETUP - 1);
    localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(CS_HOLD - 1);

    state_t            state, state_nxt;
    logic              accept;
    logic              sck_en, rise_stb, fall_stb;
    logic [PH_W-1:0]   ph_cnt;
    logic [4:0]        edge_cnt;
    logic [BYTE_W-2:0] tx_shift;
    logic [BYTE_W-1:0] rx_shift;
    logic [BYTE_W-1:0] rx_data_q;
    logic              last_q, done_q, cs_q, mosi_q;

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en       (sck_en),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .sck_o    (bus.spi_sck_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // done_q blocks acceptance so a start on the done cycle is dropped.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        sck_en    = 1'b0;
        case (state)
            IDLE: if (bus.start_i) begin
                accept    = 1'b1;
                state_nxt = SETUP;
            end
            SETUP: if (ph_cnt == SETUP_LAST) state_nxt = XFER;
            XFER: begin
                sck_en = (edge_cnt != EDGES);
                if (edge_cnt == EDGES) state_nxt = last_q ? HOLD : WAIT;
            end
            WAIT: if (bus.start_i && !done_q) begin
                accept    = 1'b1;
                state_nxt = XFER;
            end
            HOLD: if (ph_cnt == HOLD_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ph_cnt    <= '0;
            edge_cnt  <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            rx_data_q <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_q      <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (state_nxt != state)                ph_cnt <= '0;
            else if (state == SETUP || state == HOLD) ph_cnt <= ph_cnt + PH_W'(1);

            if (state != XFER)               edge_cnt <= '0;
            else if (rise_stb || fall_stb)   edge_cnt <= edge_cnt + 5'd1;

            // MSB goes straight to MOSI; the rest waits in tx_shift.
            if (accept) begin
                tx_shift <= bus.tx_data_i[BYTE_W-2:0];
                mosi_q   <= bus.tx_data_i[BYTE_W-1];
                last_q   <= bus.last_i;
                cs_q     <= 1'b0;
            end

            if (rise_stb)
                rx_shift <= {rx_shift[BYTE_W-2:0], bus.spi_miso_i};

            if (fall_stb) begin
                mosi_q   <= tx_shift[BYTE_W-2];
                tx_shift <= {tx_shift[BYTE_W-3:0], 1'b0};
            end

            if (state == XFER && edge_cnt == EDGES) begin
                rx_data_q <= rx_shift;
                done_q    <= 1'b1;
            end

            if (state == HOLD && ph_cnt == HOLD_LAST)
                cs_q <= 1'b1;
        end
    end

    assign bus.rx_data_o  = rx_data_q;
    assign bus.done_o     = done_q;
    assign bus.busy_o     = done_q || !(state == IDLE || state == WAIT);
    assign bus.spi_cs_o   = cs_q;
    assign bus.spi_mosi_o = mosi_q;

endmodule
